// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one byte-wide RAM port between the instruction-fetch
//               requester and the MEM-stage requester. Multi-byte accesses
//               run as back-to-back byte cycles and are assembled or split
//               little-endian. MEM has priority over IF.
//               Optional one-entry fetch buffer: define MEM_ARBITER_IBUF_EN.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef IDLE
`define IDLE 2'b00
`endif
`ifndef BUSY
`define BUSY 2'b01
`endif
`ifndef DONE
`define DONE 2'b10
`endif

module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_rw,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic [1:0]        if_status,
    input  logic              mem_rw,
    input  logic              mem_we,
    input  logic [1:0]        mem_width,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        mem_status,
    output logic [ADDR_W-1:0] ram_a,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic              ram_wr
);

    localparam logic [2:0] c_bytes_byte = 3'd1;
    localparam logic [2:0] c_bytes_half = 3'd2;
    localparam logic [2:0] c_bytes_word = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    state_t              state_q,      state_d;
    owner_t              owner_q,      owner_d;
    logic [ADDR_W-1:0]   addr_q,       addr_d;
    logic [2:0]          nbytes_q,     nbytes_d;
    logic [DATA_W-1:0]   wdata_q,      wdata_d;
    logic [2:0]          cyc_q,        cyc_d;
    logic [DATA_W-1:0]   rbuf_q,       rbuf_d;
    logic [DATA_W-1:0]   if_rdata_q,   if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q,  mem_rdata_d;
    logic [1:0]          if_status_q,  if_status_d;
    logic [1:0]          mem_status_q, mem_status_d;
    logic [ADDR_W-1:0]   ram_a_q,      ram_a_d;
    logic [7:0]          ram_dout_q,   ram_dout_d;
    logic                ram_wr_q,     ram_wr_d;

`ifdef MEM_ARBITER_IBUF_EN
    logic                ibuf_valid_q, ibuf_valid_d;
    logic [ADDR_W-1:0]   ibuf_addr_q,  ibuf_addr_d;
    logic [DATA_W-1:0]   ibuf_inst_q,  ibuf_inst_d;
    logic                w_ibuf_hit;
    logic                w_ibuf_overlap;
    logic [ADDR_W-1:0]   w_diff;
`endif

    logic [2:0]          w_mem_bytes;
    logic [1:0]          w_lane;

    // Next-state and next-output computation for the whole arbiter
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        nbytes_d     = nbytes_q;
        wdata_d      = wdata_q;
        cyc_d        = cyc_q;
        rbuf_d       = rbuf_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        if_status_d  = if_status_q;
        mem_status_d = mem_status_q;
        ram_a_d      = ram_a_q;
        ram_dout_d   = ram_dout_q;
        ram_wr_d     = 1'b0;

        // Width 11 is deliberately folded into the word case.
        case (mem_width)
            2'b00:   w_mem_bytes = c_bytes_byte;
            2'b01:   w_mem_bytes = c_bytes_half;
            default: w_mem_bytes = c_bytes_word;
        endcase

        // Byte lane being returned this cycle: data lags the address by one.
        w_lane = 2'(cyc_q - 3'd2);

`ifdef MEM_ARBITER_IBUF_EN
        ibuf_valid_d = ibuf_valid_q;
        ibuf_addr_d  = ibuf_addr_q;
        ibuf_inst_d  = ibuf_inst_q;
        w_ibuf_hit   = ibuf_valid_q && (ibuf_addr_q == if_addr);
        // A store byte overlaps when its offset from the buffered base,
        // taken modulo 2^ADDR_W, lands inside the 4 buffered bytes.
        w_ibuf_overlap = 1'b0;
        w_diff         = '0;
        for (int j = 0; j < 4; j++) begin
            w_diff = mem_addr + ADDR_W'(j) - ibuf_addr_q;
            if ((3'(j) < w_mem_bytes) && (w_diff < ADDR_W'(4))) begin
                w_ibuf_overlap = 1'b1;
            end
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (mem_rw) begin
                    owner_d      = OWN_MEM;
                    addr_d       = mem_addr;
                    nbytes_d     = w_mem_bytes;
                    wdata_d      = mem_wdata;
                    cyc_d        = 3'd1;
                    rbuf_d       = '0;
                    mem_status_d = `BUSY;
                    if_status_d  = `IDLE;
                    ram_a_d      = mem_addr;
                    if (mem_we) begin
                        state_d    = S_WRITE;
                        ram_wr_d   = 1'b1;
                        ram_dout_d = mem_wdata[7:0];
`ifdef MEM_ARBITER_IBUF_EN
                        if (w_ibuf_overlap) begin
                            ibuf_valid_d = 1'b0;
                        end
`endif
                    end else begin
                        state_d = S_READ;
                    end
                end else if (if_rw) begin
                    owner_d      = OWN_IF;
                    mem_status_d = `IDLE;
`ifdef MEM_ARBITER_IBUF_EN
                    if (w_ibuf_hit) begin
                        // Served from the buffer; the RAM port stays quiet.
                        state_d     = S_DONE;
                        if_status_d = `DONE;
                        if_rdata_d  = ibuf_inst_q;
                    end else begin
                        state_d     = S_READ;
                        addr_d      = if_addr;
                        nbytes_d    = c_bytes_word;
                        cyc_d       = 3'd1;
                        rbuf_d      = '0;
                        if_status_d = `BUSY;
                        ram_a_d     = if_addr;
                    end
`else
                    state_d     = S_READ;
                    addr_d      = if_addr;
                    nbytes_d    = c_bytes_word;
                    cyc_d       = 3'd1;
                    rbuf_d      = '0;
                    if_status_d = `BUSY;
                    ram_a_d     = if_addr;
`endif
                end else begin
                    if_status_d  = `IDLE;
                    mem_status_d = `IDLE;
                end
            end

            S_READ: begin
                if (cyc_q >= 3'd2) begin
                    rbuf_d[{w_lane, 3'b000} +: 8] = ram_din;
                end
                if (cyc_q < nbytes_q) begin
                    ram_a_d = addr_q + ADDR_W'(cyc_q);
                end
                if (cyc_q == (nbytes_q + 3'd1)) begin
                    state_d = S_DONE;
                    if (owner_q == OWN_MEM) begin
                        mem_status_d = `DONE;
                        mem_rdata_d  = rbuf_d;
                    end else begin
                        if_status_d  = `DONE;
                        if_rdata_d   = rbuf_d;
`ifdef MEM_ARBITER_IBUF_EN
                        ibuf_valid_d = 1'b1;
                        ibuf_addr_d  = addr_q;
                        ibuf_inst_d  = rbuf_d;
`endif
                    end
                end else begin
                    cyc_d = cyc_q + 3'd1;
                end
            end

            S_WRITE: begin
                if (cyc_q < nbytes_q) begin
                    ram_a_d    = addr_q + ADDR_W'(cyc_q);
                    ram_dout_d = wdata_q[{cyc_q[1:0], 3'b000} +: 8];
                    ram_wr_d   = 1'b1;
                    cyc_d      = cyc_q + 3'd1;
                end else begin
                    state_d      = S_DONE;
                    mem_status_d = `DONE;
                end
            end

            S_DONE: begin
                // One-cycle completion pulse; no acceptance here so a held
                // request is only re-arbitrated from the following idle cycle.
                state_d      = S_IDLE;
                if_status_d  = `IDLE;
                mem_status_d = `IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_IF;
            addr_q       <= '0;
            nbytes_q     <= '0;
            wdata_q      <= '0;
            cyc_q        <= '0;
            rbuf_q       <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            if_status_q  <= `IDLE;
            mem_status_q <= `IDLE;
            ram_a_q      <= '0;
            ram_dout_q   <= '0;
            ram_wr_q     <= 1'b0;
`ifdef MEM_ARBITER_IBUF_EN
            ibuf_valid_q <= 1'b0;
            ibuf_addr_q  <= '0;
            ibuf_inst_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            nbytes_q     <= nbytes_d;
            wdata_q      <= wdata_d;
            cyc_q        <= cyc_d;
            rbuf_q       <= rbuf_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
            if_status_q  <= if_status_d;
            mem_status_q <= mem_status_d;
            ram_a_q      <= ram_a_d;
            ram_dout_q   <= ram_dout_d;
            ram_wr_q     <= ram_wr_d;
`ifdef MEM_ARBITER_IBUF_EN
            ibuf_valid_q <= ibuf_valid_d;
            ibuf_addr_q  <= ibuf_addr_d;
            ibuf_inst_q  <= ibuf_inst_d;
`endif
        end
    end

    assign if_rdata   = if_rdata_q;
    assign if_status  = if_status_q;
    assign mem_rdata  = mem_rdata_q;
    assign mem_status = mem_status_q;
    assign ram_a      = ram_a_q;
    assign ram_dout   = ram_dout_q;
    assign ram_wr     = ram_wr_q;

endmodule

`default_nettype wire
